mem_stage_ctrl: RTL

- Memory-stage sequencer sitting directly downstream of the execute/memory pipeline register.
- Consumes the latched address, store data and memory-control bits, and drives a multi-cycle data-memory handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Presents captured load data and error status to the memory/writeback register.

---
 rtl/mem_stage_ctrl_pkg.sv | 19 +
 rtl/mem_stage_ctrl_timeout_cnt.sv | 46 ++++
 rtl/mem_stage_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage sequencer: state encoding,
// timeout default and the alignment mask for halfword accesses.
package mem_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } mem_state_e;

   localparam int unsigned TIMEOUT_DEF    = 16;
   localparam logic [15:0] MEM_ALIGN_MASK = 16'h0001;

   function automatic logic is_misaligned(input logic [15:0] addr);
      return (addr & MEM_ALIGN_MASK) != 16'h0000;
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_timeout_cnt.sv
// Generic reset flop cell and the clearable, enabled, saturating timeout
// counter built from it; tc flags the last permitted BUSY cycle.
module mem_dff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (!rst) q <= '0;
      else      q <= d;
   end
endmodule

module mem_timeout_cnt #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Saturates at TC_VAL so a stuck enable can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr)             cnt_d = '0;
      else if (en && !tc)  cnt_d = cnt_q + CNT_W'(1);
   end

   mem_dff #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .d   (cnt_d),
      .q   (cnt_q)
   );

   assign tc = (cnt_q == TC_VAL);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer: issues one data-memory request per X/M instruction,
// stalls upstream until completion, captures load data and flags errors.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addrM,
   input  logic [15:0] wrtDataM,
   input  logic        memWrtM,
   input  logic        readEnM,
   output logic        memReqEn,
   output logic        memReqWr,
   output logic [15:0] memAddr,
   output logic [15:0] memWrData,
   input  logic        memDone,
   input  logic [15:0] memRdData,
   output logic        stallM,
   output logic [15:0] readDataM,
   output logic        errM
);
   mem_state_e  state_d, state_q;
   logic [15:0] rd_data_d, rd_data_q;
   logic        req, cnt_clr, cnt_en, cnt_tc;

   assign req = memWrtM | readEnM;

   always_comb begin
      state_d   = state_q;
      rd_data_d = rd_data_q;
      memReqEn  = 1'b0;
      stallM    = 1'b0;
      cnt_clr   = 1'b1;
      cnt_en    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (is_misaligned(addrM)) begin
                  state_d = ST_ERR;
               end else begin
                  memReqEn = 1'b1;
                  stallM   = 1'b1;
                  state_d  = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            stallM  = 1'b1;
            cnt_clr = 1'b0;
            // Completion beats timeout when both land in the same cycle.
            if (memDone) begin
               if (!memWrtM) rd_data_d = memRdData;
               state_d = ST_DONE;
            end else begin
               cnt_en = 1'b1;
               if (cnt_tc) state_d = ST_ERR;
            end
         end
         // The X/M register still holds the finished instruction here.
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rd_data_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         rd_data_q <= rd_data_d;
      end
   end

   mem_timeout_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_tmo (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   assign memReqWr  = memWrtM;
   assign memAddr   = addrM;
   assign memWrData = wrtDataM;
   assign readDataM = rd_data_q;
   assign errM      = (state_q == ST_ERR);
endmodule
